// File: rtl/keyscan_pkg.sv
// Shared types and helpers for the keypad decode path.
// Keymap, FSM states and the single-bit check live here.
package keyscan_pkg;

  localparam int DEBOUNCE_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE,
    CAND,
    HELD,
    REL
  } state_t;

  // Indexed {row, col}: row-major over the 4x4 pad.
  localparam logic [3:0] KEYMAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  // True when exactly one bit is set (no popcount).
  function automatic logic one_bit(input logic [15:0] v);
    return (v != '0) && ((v & (v - 16'd1)) == '0);
  endfunction

  // Position of the highest set bit; meaningful for one-hot v.
  function automatic logic [3:0] bit_index(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_frame.sv
// Assembles one 16-key snapshot per scanner frame.
// Frame closes on the write that completes the seen mask.
module keypad_frame
  import keyscan_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rcbits,
  output logic        frame_done,
  output logic [15:0] snapshot
);

  logic [3:0]      seen;
  logic [3:0]      seen_n;
  logic [3:0][3:0] slot;
  logic [3:0][3:0] slot_n;
  logic            col_ok;
  logic [1:0]      cidx;

  // Merge this cycle's column into the frame and map to {r,c}.
  always_comb begin
    col_ok = one_bit({12'd0, rcbits[3:0]});
    case (rcbits[3:0])
      4'b1000: cidx = 2'd0;
      4'b0100: cidx = 2'd1;
      4'b0010: cidx = 2'd2;
      4'b0001: cidx = 2'd3;
      default: cidx = 2'd0;
    endcase
    slot_n = slot;
    seen_n = seen;
    if (col_ok) begin
      slot_n[cidx] = rcbits[7:4];
      seen_n = seen | rcbits[3:0];
    end
    frame_done = col_ok && (seen_n == 4'hF);
    snapshot = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        snapshot[r*4 + c] = slot_n[c][3-r];
      end
    end
  end

  // Hold partial frame; wipe it once the snapshot is taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seen <= '0;
      slot <= '0;
    end else if (frame_done) begin
      seen <= '0;
      slot <= '0;
    end else begin
      seen <= seen_n;
      slot <= slot_n;
    end
  end

endmodule

// File: rtl/keypad_decode.sv
// Debounces keypad snapshots into hex key events.
// Press and release each need DEBOUNCE_FRAMES equal frames.
module keypad_decode
  import keyscan_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = DEBOUNCE_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rcbits,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_down
);

  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CW-1:0] DF = CW'(DEBOUNCE_FRAMES);
  localparam logic [CW-1:0] C1 = CW'(1);
  localparam bit ONE = (DEBOUNCE_FRAMES == 1);

  logic          frame_done;
  logic [15:0]   snapshot;
  logic          is_zero;
  logic          is_single;
  logic [3:0]    code;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [3:0]    cand_code;
  state_t        state;

  keypad_frame u_frame (
    .clk        (clk),
    .reset      (reset),
    .rcbits     (rcbits),
    .frame_done (frame_done),
    .snapshot   (snapshot)
  );

  // Classify the snapshot and look up its hex code.
  always_comb begin
    is_zero   = (snapshot == '0);
    is_single = one_bit(snapshot);
    code      = KEYMAP[bit_index(snapshot)];
    cnt_inc   = cnt + C1;
  end

  // Debounce FSM; outputs registered, evaluated at frame end.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cand_code <= '0;
      key       <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (frame_done) begin
        unique case (state)
          IDLE: begin
            if (is_single) begin
              if (ONE) begin
                state     <= HELD;
                key       <= code;
                key_valid <= 1'b1;
                key_down  <= 1'b1;
              end else begin
                state     <= CAND;
                cand_code <= code;
                cnt       <= C1;
              end
            end
          end
          CAND: begin
            if (is_single && code == cand_code) begin
              if (cnt_inc == DF) begin
                state     <= HELD;
                key       <= cand_code;
                key_valid <= 1'b1;
                key_down  <= 1'b1;
                cnt       <= '0;
              end else begin
                cnt <= cnt_inc;
              end
            end else if (is_single) begin
              cand_code <= code;
              cnt       <= C1;
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
          HELD: begin
            if (is_zero) begin
              if (ONE) begin
                state    <= IDLE;
                key_down <= 1'b0;
              end else begin
                state <= REL;
                cnt   <= C1;
              end
            end
          end
          REL: begin
            if (is_zero) begin
              if (cnt_inc == DF) begin
                state    <= IDLE;
                key_down <= 1'b0;
                cnt      <= '0;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              state <= HELD;
              cnt   <= '0;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_decode.sv
// Bench for keypad_decode at DEBOUNCE_FRAMES 4 and 1.
// Frame-level run-length model checked every cycle.
module tb_keypad_decode;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rcbits = 8'h00;
  logic [3:0] key4, key1;
  logic       kv4, kv1, kd4, kd1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  keypad_decode #(.DEBOUNCE_FRAMES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .rcbits    (rcbits),
    .key       (key4),
    .key_valid (kv4),
    .key_down  (kd4)
  );

  keypad_decode #(.DEBOUNCE_FRAMES(1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .rcbits    (rcbits),
    .key       (key1),
    .key_valid (kv1),
    .key_down  (kd1)
  );

  logic [3:0] kmap [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };
  logic [3:0] junk_cols [5] = '{4'b0000, 4'b1100, 4'b1010, 4'b0111, 4'b1111};

  int         df [2] = '{4, 1};
  bit         held [2];
  int         run [2];
  logic [15:0] prev [2];
  logic [3:0] m_key [2];
  bit         m_pulse [2];

  localparam logic [15:0] K5 = 16'h0020;
  localparam logic [15:0] KD = 16'h8000;
  localparam logic [15:0] K9 = 16'h0400;
  localparam logic [15:0] KA = 16'h0008;
  localparam logic [15:0] K0 = 16'h2000;
  localparam logic [15:0] K12 = 16'h0003;

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      held[m] = 0;
      run[m] = 0;
      prev[m] = '0;
      m_key[m] = 4'h0;
      m_pulse[m] = 0;
    end
  endtask

  // Trailing run of identical frames decides press/release.
  task automatic model_frame(input logic [15:0] s);
    int pos;
    pos = 0;
    for (int i = 0; i < 16; i++) if (s[i]) pos = i;
    for (int m = 0; m < 2; m++) begin
      m_pulse[m] = 0;
      run[m] = (s == prev[m]) ? run[m] + 1 : 1;
      prev[m] = s;
      if (!held[m] && $countones(s) == 1 && run[m] == df[m]) begin
        held[m] = 1;
        m_key[m] = kmap[pos];
        m_pulse[m] = 1;
        run[m] = 0;
      end else if (held[m] && s == 16'h0 && run[m] == df[m]) begin
        held[m] = 0;
        run[m] = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("valid_df4", {7'd0, kv4}, {7'd0, m_pulse[0]});
    chk("key_df4", {4'd0, key4}, {4'd0, m_key[0]});
    chk("down_df4", {7'd0, kd4}, {7'd0, held[0]});
    chk("valid_df1", {7'd0, kv1}, {7'd0, m_pulse[1]});
    chk("key_df1", {4'd0, key1}, {4'd0, m_key[1]});
    chk("down_df1", {7'd0, kd1}, {7'd0, held[1]});
  endtask

  task automatic step(input logic [7:0] rc, input bit done,
                      input logic [15:0] s);
    rcbits = rc;
    @(posedge clk);
    #1;
    if (done) model_frame(s);
    else begin
      m_pulse[0] = 0;
      m_pulse[1] = 0;
    end
    check_all();
  endtask

  function automatic logic [7:0] col_word(input logic [15:0] s, input int c);
    logic [7:0] w;
    w = 8'h00;
    w[3-c] = 1'b1;
    for (int r = 0; r < 4; r++) w[7-r] = s[r*4 + c];
    return w;
  endfunction

  task automatic frame(input logic [15:0] s, input bit shuffle,
                       input int junk);
    int order [4];
    int j, t;
    logic [7:0] jw;
    for (int i = 0; i < 4; i++) order[i] = i;
    if (shuffle) begin
      for (int i = 3; i > 0; i--) begin
        j = $urandom_range(0, i);
        t = order[i];
        order[i] = order[j];
        order[j] = t;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        repeat (junk) begin
          jw = {4'($urandom_range(0, 15)), junk_cols[$urandom_range(0, 4)]};
          step(jw, 1'b0, s);
        end
      end
      step(col_word(s, order[i]), i == 3, s);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [15:0] s;
    int a, b, n;
    model_reset();
    #12;
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Interrupted press never accepted at DF 4.
    repeat (3) frame(K5, 1'b0, 0);
    frame(16'h0, 1'b0, 0);
    repeat (3) frame(K5, 1'b0, 0);
    chk("bounce_key_stays0", {4'd0, key4}, 8'h00);
    chk("bounce_no_down", {7'd0, kd4}, 8'h00);
    frame(16'h0, 1'b0, 0);
    do_reset();

    // Clean press: pulse lands in cycle 16.
    repeat (4) frame(K5, 1'b0, 0);
    chk("press_c16_valid", {7'd0, kv4}, 8'h01);
    chk("press_c16_key", {4'd0, key4}, 8'h05);
    chk("press_c16_down", {7'd0, kd4}, 8'h01);
    repeat (2) frame(K5, 1'b0, 0);

    // Release bounce then a full release.
    repeat (2) frame(16'h0, 1'b0, 0);
    frame(K5, 1'b0, 0);
    repeat (3) frame(16'h0, 1'b0, 0);
    chk("rel_still_down", {7'd0, kd4}, 8'h01);
    frame(16'h0, 1'b0, 0);
    chk("rel_down_low", {7'd0, kd4}, 8'h00);

    // Two keys together never count; then D alone.
    repeat (8) frame(K12, 1'b0, 0);
    chk("multi_key_kept", {4'd0, key4}, 8'h05);
    repeat (4) frame(KD, 1'b0, 0);
    chk("keyd_valid", {7'd0, kv4}, 8'h01);
    chk("keyd_code", {4'd0, key4}, 8'h0D);
    repeat (4) frame(16'h0, 1'b0, 0);

    // Invalid column codes injected mid-frame.
    frame(K9, 1'b0, 1);
    frame(K9, 1'b0, 2);
    frame(K9, 1'b0, 0);
    frame(K9, 1'b0, 1);
    chk("junk_key9", {4'd0, key4}, 8'h09);
    repeat (4) frame(16'h0, 1'b0, 0);

    // Reset during candidate debounce discards progress.
    repeat (2) frame(KA, 1'b0, 0);
    step(col_word(KA, 0), 1'b0, KA);
    step(col_word(KA, 1), 1'b0, KA);
    do_reset();
    chk("rst_key0", {4'd0, key4}, 8'h00);
    repeat (3) frame(KA, 1'b0, 0);
    chk("rst_no_early", {7'd0, kv4}, 8'h00);
    frame(KA, 1'b0, 0);
    chk("rst_keya_valid", {7'd0, kv4}, 8'h01);
    chk("rst_keya_code", {4'd0, key4}, 8'h0A);
    repeat (4) frame(16'h0, 1'b0, 0);

    // Single-frame debounce accepts key 0 at once.
    do_reset();
    frame(K0, 1'b0, 0);
    chk("df1_valid", {7'd0, kv1}, 8'h01);
    chk("df1_key", {4'd0, key1}, 8'h00);
    chk("df1_down", {7'd0, kd1}, 8'h01);
    frame(16'h0, 1'b0, 0);
    chk("df1_release", {7'd0, kd1}, 8'h00);

    // Random runs of zero, single and multi frames.
    for (int it = 0; it < 60; it++) begin
      a = $urandom_range(0, 15);
      case ($urandom_range(0, 2))
        0: s = 16'h0;
        1: s = 16'h1 << a;
        default: begin
          b = (a + $urandom_range(1, 15)) % 16;
          s = (16'h1 << a) | (16'h1 << b);
        end
      endcase
      n = (s == 16'h0) ? $urandom_range(1, 6) : $urandom_range(1, 6);
      repeat (n) frame(s, 1'b1, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
